cyl_to_sph: RTL and testbench

CYL_TO_SPH -- requirements
Module: cyl_to_sph

---
 rtl/cyl_to_sph_pkg.sv | 25 ++
 rtl/cyl_to_sph_cordic_vec_step.sv | 34 +++
 rtl/cyl_to_sph.sv | 146 ++++++++++++++
 tb/tb_cyl_to_sph.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cyl_to_sph_pkg.sv
// Shared types and constants for the cylindrical-to-spherical converter.
// Angles are in pi/2048 units on the accumulator side.
package cyl_to_sph_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        SCALE,
        DONE
    } state_e;

    localparam int unsigned CORDIC_ITERS = 8;
    localparam int unsigned GAIN_NUM     = 155;
    localparam logic [11:0] ANGLE_90     = 12'd1024;

    localparam logic [11:0] ATAN_TABLE [CORDIC_ITERS] = '{
        12'd512, 12'd302, 12'd160, 12'd81, 12'd41, 12'd20, 12'd10, 12'd5
    };

    function automatic logic [11:0] atan_lookup(input logic [2:0] i);
        return ATAN_TABLE[i];
    endfunction

endpackage

// File: rtl/cyl_to_sph_cordic_vec_step.sv
// One combinational CORDIC vectoring iteration; drives y toward zero and
// accumulates the rotation angle.
module cordic_vec_step
    import cyl_to_sph_pkg::*;
(
    input  logic signed [11:0] x,
    input  logic signed [11:0] y,
    input  logic        [11:0] acc,
    input  logic        [2:0]  i,
    output logic signed [11:0] x_next,
    output logic signed [11:0] y_next,
    output logic        [11:0] acc_next
);

    logic signed [11:0] x_sh;
    logic signed [11:0] y_sh;
    logic        [11:0] step;

    always_comb begin
        x_sh = x >>> i;
        y_sh = y >>> i;
        step = atan_lookup(i);
        if (!y[11]) begin
            x_next   = x + y_sh;
            y_next   = y - x_sh;
            acc_next = acc + step;
        end else begin
            x_next   = x - y_sh;
            y_next   = y + x_sh;
            acc_next = acc - step;
        end
    end

endmodule

// File: rtl/cyl_to_sph.sv
// Cylindrical (r, theta, z) to spherical (rho, theta, phi) converter using a
// multi-cycle CORDIC vectoring engine with one shared iteration stage.
module cyl_to_sph
    import cyl_to_sph_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] r,
    input  logic [7:0] theta,
    input  logic [7:0] z,
    output logic [7:0] rho,
    output logic [7:0] phi,
    output logic [7:0] theta_out,
    output logic       busy,
    output logic       done
);

    state_e state_q, state_d;

    logic        [2:0]  iter_q;
    logic        [7:0]  r_q, theta_q, z_q;
    logic signed [11:0] x_q, y_q;
    logic        [11:0] acc_q;
    logic        [7:0]  rho_q, phi_q, theta_out_q;

    logic signed [11:0] x_step, y_step;
    logic        [11:0] acc_step;
    logic signed [11:0] x_init, y_init, z_ext, r_ext;
    logic        [11:0] acc_init;
    logic        [10:0] x_pos;
    logic        [19:0] prod;
    logic        [9:0]  rho_wide;
    logic        [7:0]  rho_res, phi_res;

    cordic_vec_step u_step (
        .x        (x_q),
        .y        (y_q),
        .acc      (acc_q),
        .i        (iter_q),
        .x_next   (x_step),
        .y_next   (y_step),
        .acc_next (acc_step)
    );

    // Vectors with z<0 are pre-rotated by -90 deg so CORDIC only sees the right half-plane.
    always_comb begin
        z_ext = {{2{z_q[7]}}, z_q, 2'b00};
        r_ext = {2'b00, r_q, 2'b00};
        if (z_q[7]) begin
            x_init   = r_ext;
            y_init   = -z_ext;
            acc_init = ANGLE_90;
        end else begin
            x_init   = z_ext;
            y_init   = r_ext;
            acc_init = '0;
        end
    end

    always_comb begin
        x_pos    = x_q[11] ? 11'd0 : x_q[10:0];
        prod     = 20'(x_pos) * 20'(GAIN_NUM) + 20'd512;
        rho_wide = 10'(prod >> 10);
        rho_res  = (|rho_wide[9:8]) ? 8'hff : rho_wide[7:0];
        phi_res  = 8'((acc_q + 12'd8) >> 4);
        if (r_q == 8'd0 && z_q == 8'd0) begin
            rho_res = 8'd0;
            phi_res = 8'd0;
        end else if (r_q == 8'd0) begin
            phi_res = z_q[7] ? 8'd128 : 8'd0;
        end else if (z_q == 8'd0) begin
            phi_res = 8'd64;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = PREP;
            end
            PREP:  state_d = ITER;
            ITER:  if (iter_q == 3'(CORDIC_ITERS - 1)) state_d = SCALE;
            SCALE: state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            r_q         <= '0;
            theta_q     <= '0;
            z_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            rho_q       <= '0;
            phi_q       <= '0;
            theta_out_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        r_q     <= r;
                        theta_q <= theta;
                        z_q     <= z;
                    end
                end
                PREP: begin
                    x_q    <= x_init;
                    y_q    <= y_init;
                    acc_q  <= acc_init;
                    iter_q <= '0;
                end
                ITER: begin
                    x_q    <= x_step;
                    y_q    <= y_step;
                    acc_q  <= acc_step;
                    iter_q <= iter_q + 3'd1;
                end
                SCALE: begin
                    rho_q       <= rho_res;
                    phi_q       <= phi_res;
                    theta_out_q <= theta_q;
                end
                default: ;
            endcase
        end
    end

    assign rho       = rho_q;
    assign phi       = phi_q;
    assign theta_out = theta_out_q;

endmodule

// File: tb/tb_cyl_to_sph.sv
// Scoreboard bench for cyl_to_sph: stimulus queues expected results, a
// negedge monitor checks every done pulse against the queue.
module tb_cyl_to_sph;

    typedef struct {
        int         rho;
        int         rtol;
        int         phi;
        int         ptol;
        logic [7:0] th;
        int         acc_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] r, theta, z;
    logic [7:0] rho, phi, theta_out;
    logic       busy, done;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   chk_after_done = 1'b0;
    exp_t exp_q[$];

    cyl_to_sph dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .r         (r),
        .theta     (theta),
        .z         (z),
        .rho       (rho),
        .phi       (phi),
        .theta_out (theta_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req, input int tol);
        int d;
        d = act - req;
        if (d < 0) d = -d;
        total++;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (+-%0d) at cycle %0d", name, act, req, tol, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (chk_after_done) begin
            chk_after_done = 1'b0;
            check("busy_after_done", int'(busy), 0, 0);
            check("done_one_cycle", int'(done), 0, 0);
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 with no pending request, want 0 at cycle %0d",
                         cyc);
            end else begin
                e = exp_q.pop_front();
                check("rho", int'(rho), e.rho, e.rtol);
                check("phi", int'(phi), e.phi, e.ptol);
                check("theta_out", int'(theta_out), int'(e.th), 0);
                check("latency", cyc - e.acc_cyc + 1, 11, 0);
                chk_after_done = 1'b1;
            end
        end
    end

    task automatic convert(input logic [7:0] rv, input logic [7:0] tv, input logic [7:0] zv,
                           input int rho_e, input int rt, input int phi_e, input int pt,
                           input bit expect_result);
        exp_t e;
        @(negedge clk);
        r     = rv;
        theta = tv;
        z     = zv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        r     = 8'($urandom);
        theta = 8'($urandom);
        z     = 8'($urandom);
        check("busy_after_accept", int'(busy), 1, 0);
        if (expect_result) begin
            e = '{rho_e, rt, phi_e, pt, tv, cyc};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d results still pending after %0d cycles, want 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   c0;
        rst   = 1'b1;
        start = 1'b0;
        r     = '0;
        theta = '0;
        z     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rho", int'(rho), 0, 0);
        check("reset_phi", int'(phi), 0, 0);
        check("reset_theta_out", int'(theta_out), 0, 0);
        check("reset_busy", int'(busy), 0, 0);
        check("reset_done", int'(done), 0, 0);
        rst = 1'b0;

        // Directed conversions: rho/phi expectations hand-derived from the geometry.
        convert(8'd100, 8'h25, 8'd0, 100, 2, 64, 0, 1'b1);
        wait_empty(40);
        convert(8'd30, 8'h11, 8'd40, 50, 2, 26, 1, 1'b1);
        wait_empty(40);
        convert(8'd0, 8'h80, 8'h80, 128, 2, 128, 0, 1'b1);
        wait_empty(40);
        convert(8'd255, 8'hc3, 8'd127, 255, 0, 45, 1, 1'b1);
        wait_empty(40);
        convert(8'd0, 8'h01, 8'd50, 50, 2, 0, 0, 1'b1);
        wait_empty(40);
        convert(8'd200, 8'h9c, 8'h9c, 224, 2, 83, 1, 1'b1);
        wait_empty(40);

        // A start raised mid-conversion must be dropped.
        convert(8'd60, 8'h33, 8'd80, 100, 2, 26, 1, 1'b1);
        repeat (3) @(negedge clk);
        r     = 8'd5;
        z     = 8'hfb;
        theta = 8'hee;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty(40);
        repeat (5) @(negedge clk);

        // start held high: accepts every 12 cycles.
        @(negedge clk);
        r     = 8'd100;
        z     = 8'd0;
        theta = 8'h7f;
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            e = '{100, 2, 64, 0, 8'h7f, c0 + 12 * k};
            exp_q.push_back(e);
        end
        repeat (24) @(posedge clk);
        #1;
        start = 1'b0;
        wait_empty(60);

        // Reset during ITER abandons the conversion.
        convert(8'd100, 8'h44, 8'd50, 0, 0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_rho", int'(rho), 0, 0);
        check("midrst_phi", int'(phi), 0, 0);
        check("midrst_theta_out", int'(theta_out), 0, 0);
        check("midrst_busy", int'(busy), 0, 0);
        check("midrst_done", int'(done), 0, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        convert(8'd0, 8'h5a, 8'd0, 0, 0, 0, 0, 1'b1);
        wait_empty(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
